// File: rtl/reaction_pkg.sv
// Shared types and constants for the F1 reaction-time controller.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SEQ,
    TIMING,
    DONE,
    FAULT
  } state_t;

  localparam logic [7:0]  LIGHTS_ALL_ON = 8'hFF;
  localparam logic [7:0]  LIGHTS_OFF    = 8'h00;
  localparam logic [15:0] MS_SAT        = 16'hFFFF;

endpackage

// File: rtl/ms_prescaler.sv
// Divides clk by MS_DIV while enabled; ms_tick is high during the last
// enabled cycle of each millisecond, so the owner can count it at the wrap edge.
module ms_prescaler #(
  parameter int MS_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic ms_tick
);

  localparam int CW = (MS_DIV > 2) ? $clog2(MS_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(MS_DIV - 1);

  logic [CW-1:0] cnt;

  assign ms_tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= ms_tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/reaction_ctrl.sv
// Game sequencer: triggers the start lights, times the player's reaction in ms,
// flags jump starts and time-outs. Define BEST_TIME_EN to keep the best time.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int MS_DIV     = 1000,
  parameter int TIMEOUT_MS = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        btn,
  input  logic [7:0]  lights,
  output logic        trigger,
  output logic        busy,
  output logic [15:0] react_ms,
  output logic        result_valid,
  output logic        jump_start,
  output logic        timeout,
  output logic [15:0] best_ms
);

  state_t      state;
  state_t      state_nxt;
  logic        btn_q;
  logic [7:0]  lights_q;
  logic        press;
  logic        lights_out;
  logic        ms_tick;
  logic [15:0] ms_cnt;
  logic [15:0] ms_next;
  logic        hit_timeout;

  assign press       = btn & ~btn_q;
  assign lights_out  = (lights_q == LIGHTS_ALL_ON) && (lights == LIGHTS_OFF);
  // ms_next already includes the millisecond completing this cycle, so a
  // press after exactly k*MS_DIV timing cycles reports k.
  assign ms_next     = ms_cnt + {15'd0, ms_tick};
  assign hit_timeout = (ms_next == 16'(TIMEOUT_MS));

  ms_prescaler #(.MS_DIV(MS_DIV)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != TIMING),
    .en      (state == TIMING),
    .ms_tick (ms_tick)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (start) state_nxt = ARM;
      ARM:         state_nxt = SEQ;
      SEQ: begin
        if (press)           state_nxt = FAULT;
        else if (lights_out) state_nxt = TIMING;
      end
      TIMING:      if (press || hit_timeout) state_nxt = DONE;
      DONE, FAULT: if (start) state_nxt = ARM;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      btn_q        <= 1'b0;
      lights_q     <= 8'h00;
      ms_cnt       <= 16'd0;
      react_ms     <= 16'h0000;
      trigger      <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      jump_start   <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      btn_q        <= btn;
      lights_q     <= lights;
      state        <= state_nxt;
      trigger      <= (state_nxt == ARM);
      busy         <= (state_nxt inside {ARM, SEQ, TIMING});
      result_valid <= (state_nxt == DONE);
      jump_start   <= (state_nxt == FAULT);

      if (state == SEQ) begin
        ms_cnt <= 16'd0;
      end else if (state == TIMING) begin
        ms_cnt <= ms_next;
      end

      if (state == TIMING && state_nxt == DONE) begin
        if (press) begin
          react_ms <= ms_next;
          timeout  <= 1'b0;
        end else begin
          react_ms <= MS_SAT;
          timeout  <= 1'b1;
        end
      end else if (state_nxt != DONE) begin
        timeout <= 1'b0;
      end
    end
  end

`ifdef BEST_TIME_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      best_ms <= MS_SAT;
    end else if (state == TIMING && press && ms_next < best_ms) begin
      best_ms <= ms_next;
    end
  end
`else
  assign best_ms = MS_SAT;
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with MS_DIV=4, TIMEOUT_MS=10: a table of
// rounds plus hand-written reset and start-up sequences.
module tb_reaction_ctrl;

  localparam int MS_DIV     = 4;
  localparam int TIMEOUT_MS = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        btn;
  logic [7:0]  lights;
  logic        trigger;
  logic        busy;
  logic [15:0] react_ms;
  logic        result_valid;
  logic        jump_start;
  logic        timeout;
  logic [15:0] best_ms;

  reaction_ctrl #(.MS_DIV(MS_DIV), .TIMEOUT_MS(TIMEOUT_MS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .btn          (btn),
    .lights       (lights),
    .trigger      (trigger),
    .busy         (busy),
    .react_ms     (react_ms),
    .result_valid (result_valid),
    .jump_start   (jump_start),
    .timeout      (timeout),
    .best_ms      (best_ms)
  );

  always #5 clk = ~clk;

  typedef enum int {K_NORMAL, K_JUMP, K_COINC, K_TIMEOUT} kind_t;
  typedef struct {
    kind_t       kind;
    int          delay;
    logic [15:0] exp_react;
    logic        exp_timeout;
  } round_t;

  round_t      rounds[11];
  logic [15:0] exp_q[$];
  logic [15:0] exp_best;
  bit          best_en;
  int          checks = 0;
  int          errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic arm_round();
    start = 1'b1;
    step();
    start = 1'b0;
    check1("trigger_pulse", trigger, 1'b1);
    check1("busy_arm", busy, 1'b1);
    lights = 8'h01;
    step();
    check1("trigger_drop", trigger, 1'b0);
    check1("busy_seq", busy, 1'b1);
  endtask

  task automatic run_round(input round_t r);
    logic [7:0]  ramp;
    logic [15:0] exp_r;
    int          n;
    exp_q.push_back(r.exp_react);
    arm_round();
    ramp = 8'h01;
    for (int i = 0; i < 7; i++) begin
      ramp   = {ramp[6:0], 1'b1};
      lights = ramp;
      if (r.kind == K_JUMP && ramp == 8'h3F) btn = 1'b1;
      step();
      if (r.kind == K_JUMP && ramp == 8'h3F) break;
    end

    if (r.kind == K_JUMP) begin
      exp_r = exp_q.pop_front();
      check1("jump_flag", jump_start, 1'b1);
      check1("jump_busy", busy, 1'b0);
      check1("jump_no_result", result_valid, 1'b0);
      check16("jump_react_kept", react_ms, exp_r);
    end else begin
      lights = 8'h00;
      if (r.kind == K_COINC) btn = 1'b1;
      step();
      if (r.kind == K_COINC) begin
        exp_r = exp_q.pop_front();
        check1("coinc_jump_flag", jump_start, 1'b1);
        check1("coinc_no_result", result_valid, 1'b0);
        check16("coinc_react_kept", react_ms, exp_r);
      end else if (r.kind == K_TIMEOUT) begin
        n = 0;
        while (!result_valid && n < 60) begin
          step();
          n++;
        end
        exp_r = exp_q.pop_front();
        check16("timeout_cycles", 16'(n), 16'd40);
        check1("timeout_valid", result_valid, 1'b1);
        check1("timeout_flag", timeout, r.exp_timeout);
        check16("timeout_react", react_ms, exp_r);
        check16("timeout_best", best_ms, exp_best);
      end else begin
        for (int i = 1; i < r.delay; i++) begin
          if (i == 1) start = 1'b1;
          step();
        end
        start = 1'b0;
        check1("wait_no_trigger", trigger, 1'b0);
        check1("wait_busy", busy, 1'b1);
        check1("wait_no_result", result_valid, 1'b0);
        btn = 1'b1;
        step();
        exp_r = exp_q.pop_front();
        if (best_en && exp_r < exp_best) exp_best = exp_r;
        check1("done_valid", result_valid, 1'b1);
        check16("done_react", react_ms, exp_r);
        check1("done_timeout", timeout, r.exp_timeout);
        check1("done_busy", busy, 1'b0);
        check1("done_jump", jump_start, 1'b0);
        check16("done_best", best_ms, exp_best);
      end
    end

    btn    = 1'b0;
    lights = 8'h00;
    step();
    if (r.kind == K_JUMP || r.kind == K_COINC) begin
      check1("fault_hold", jump_start, 1'b1);
    end else begin
      check1("done_hold", result_valid, 1'b1);
      check16("done_hold_react", react_ms, r.exp_react);
    end
  endtask

  initial begin
`ifdef BEST_TIME_EN
    best_en = 1'b1;
`else
    best_en = 1'b0;
`endif
    exp_best = 16'hFFFF;

    rounds[0]  = '{K_NORMAL,  20, 16'd5,     1'b0};
    rounds[1]  = '{K_NORMAL,   8, 16'd2,     1'b0};
    rounds[2]  = '{K_NORMAL,  31, 16'd7,     1'b0};
    rounds[3]  = '{K_NORMAL,  14, 16'd3,     1'b0};
    rounds[4]  = '{K_JUMP,     0, 16'd3,     1'b0};
    rounds[5]  = '{K_COINC,    0, 16'd3,     1'b0};
    rounds[6]  = '{K_TIMEOUT,  0, 16'hFFFF,  1'b1};
    rounds[7]  = '{K_JUMP,     0, 16'hFFFF,  1'b0};
    rounds[8]  = '{K_NORMAL,   3, 16'd0,     1'b0};
    rounds[9]  = '{K_NORMAL,  39, 16'd9,     1'b0};
    rounds[10] = '{K_NORMAL,  40, 16'd10,    1'b0};

    rst    = 1'b1;
    start  = 1'b0;
    btn    = 1'b0;
    lights = 8'h00;
    step();
    step();
    rst = 1'b0;
    check1("rst_trigger", trigger, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check16("rst_react", react_ms, 16'h0000);
    check1("rst_valid", result_valid, 1'b0);
    check1("rst_jump", jump_start, 1'b0);
    check1("rst_timeout", timeout, 1'b0);
    check16("rst_best", best_ms, 16'hFFFF);
    step();
    check1("idle_no_trigger", trigger, 1'b0);

    for (int i = 0; i < 11; i++) run_round(rounds[i]);

    arm_round();
    lights = 8'hFF;
    step();
    lights = 8'h00;
    step();
    for (int i = 0; i < 5; i++) step();
    check1("mid_busy", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_trigger", trigger, 1'b0);
    check16("midrst_react", react_ms, 16'h0000);
    check1("midrst_valid", result_valid, 1'b0);
    check16("midrst_best", best_ms, 16'hFFFF);
    step();
    check1("midrst_idle_trigger", trigger, 1'b0);
    btn = 1'b1;
    step();
    btn = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check1("midrst_btn_no_result", result_valid, 1'b0);
    check1("midrst_btn_busy", busy, 1'b0);
    check16("midrst_btn_react", react_ms, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
